// File: rtl/otn_frame_pkg.sv
// Shared constants, state encoding and the bit-serial CRC-8 step used by the
// OTN-style frame receiver and the sender's mapper.
package otn_frame_pkg;

  localparam logic [15:0] FAS_DEFAULT = 16'hF628;
  localparam logic [7:0]  CRC8_POLY   = 8'h07;
  localparam logic [7:0]  CRC8_INIT   = 8'h00;

  typedef enum logic [2:0] {
    HUNT  = 3'd0,
    RECV  = 3'd1,
    CHECK = 3'd2,
    DRAIN = 3'd3,
    ACK   = 3'd4
  } rx_state_e;

  // One MSB-first CRC-8 update for a single line bit (no reflection).
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
    logic fb;
    fb = crc[7] ^ bit_in;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR).
// clr has priority over bit_en so a new frame always starts from the seed.
module crc8_serial
  import otn_frame_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       bit_en,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_d, crc_q;

  // Next CRC: reseed, fold in one bit, or hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    crc_d = crc_q;
    if (clr) begin
      crc_d = CRC8_INIT;
    end else if (bit_en) begin
      crc_d = crc8_step(crc_q, bit_in);
    end
  end

  // CRC register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) crc_q <= CRC8_INIT;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/otn_frame_rx.sv
// OTN-style line receiver: hunts for FAS, buffers PYLD_LEN payload bytes,
// checks the trailing CRC-8, drains good payload downstream and returns the
// ARQ acknowledge to the sender.
module otn_frame_rx
  import otn_frame_pkg::*;
#(
  parameter int          PYLD_LEN = 4,
  parameter int          ACK_LEN  = 16,
  parameter logic [15:0] FAS_WORD = FAS_DEFAULT
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_otn_data,
  input  logic       i_otn_data_en,
  input  logic       i_arq_en,
  output logic [7:0] o_pyld_data,
  output logic       o_pyld_data_valid,
  input  logic       i_pyld_data_ready,
  output logic       o_pyld_last,
  output logic       o_otn_tx_ack,
  output logic       o_frame_ok,
  output logic       o_frame_err,
  output logic       o_sync
);

  localparam int               IDX_W      = (PYLD_LEN > 1) ? $clog2(PYLD_LEN) : 1;
  localparam int               ACK_W      = $clog2(ACK_LEN + 1);
  localparam logic [7:0]       PYLD_LEN_B = 8'(PYLD_LEN);
  localparam logic [7:0]       LAST_IDX   = 8'(PYLD_LEN - 1);
  localparam logic [ACK_W-1:0] ACK_LAST   = ACK_W'(ACK_LEN - 1);

  rx_state_e        state_d, state_q;
  logic [15:0]      shreg_d, shreg_q;
  logic [2:0]       bit_cnt_d, bit_cnt_q;
  logic [7:0]       byte_cnt_d, byte_cnt_q;
  logic [7:0]       byte_sr_d, byte_sr_q;
  logic [7:0]       rx_crc_d, rx_crc_q;
  logic [7:0]       rd_ptr_d, rd_ptr_q;
  logic [ACK_W-1:0] ack_cnt_d, ack_cnt_q;
  logic [7:0]       pyld_data_d, pyld_data_q;
  logic             pyld_valid_d, pyld_valid_q;
  logic             pyld_last_d, pyld_last_q;
  logic             ack_d, ack_q;
  logic             frame_ok_d, frame_ok_q;
  logic             frame_err_d, frame_err_q;
  logic             sync_d, sync_q;

  logic [7:0]       pyld_buf [PYLD_LEN];
  logic             buf_we;
  logic [IDX_W-1:0] buf_waddr;

  logic             crc_clr, crc_en;
  logic [7:0]       crc;

  crc8_serial u_crc (
    .clk    (i_clk),
    .rst    (i_rst),
    .clr    (crc_clr),
    .bit_en (crc_en),
    .bit_in (i_otn_data),
    .crc    (crc)
  );

  assign buf_waddr = byte_cnt_q[IDX_W-1:0];

  // Frame FSM next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    byte_sr_d    = byte_sr_q;
    rx_crc_d     = rx_crc_q;
    rd_ptr_d     = rd_ptr_q;
    ack_cnt_d    = ack_cnt_q;
    pyld_data_d  = pyld_data_q;
    pyld_valid_d = pyld_valid_q;
    pyld_last_d  = pyld_last_q;
    ack_d        = ack_q;
    frame_ok_d   = 1'b0;
    frame_err_d  = 1'b0;
    buf_we       = 1'b0;
    crc_clr      = 1'b0;
    crc_en       = 1'b0;

    unique case (state_q)
      HUNT: begin
        crc_clr    = 1'b1;
        bit_cnt_d  = 3'd0;
        byte_cnt_d = 8'd0;
        if (i_otn_data_en) begin
          shreg_d = {shreg_q[14:0], i_otn_data};
          if (shreg_d == FAS_WORD) state_d = RECV;
        end
      end

      RECV: begin
        if (i_otn_data_en) begin
          byte_sr_d = {byte_sr_q[6:0], i_otn_data};
          bit_cnt_d = bit_cnt_q + 3'd1;
          crc_en    = (byte_cnt_q < PYLD_LEN_B);
          if (bit_cnt_q == 3'd7) begin
            if (byte_cnt_q < PYLD_LEN_B) begin
              buf_we     = 1'b1;
              byte_cnt_d = byte_cnt_q + 8'd1;
            end else begin
              rx_crc_d = byte_sr_d;
              state_d  = CHECK;
            end
          end
        end
      end

      CHECK: begin
        frame_ok_d  = (crc == rx_crc_q);
        frame_err_d = (crc != rx_crc_q);
        if ((crc == rx_crc_q) || !i_arq_en) begin
          state_d      = DRAIN;
          rd_ptr_d     = 8'd0;
          pyld_valid_d = 1'b1;
          pyld_data_d  = pyld_buf[0];
          pyld_last_d  = (LAST_IDX == 8'd0);
        end else begin
          state_d = HUNT;
        end
      end

      DRAIN: begin
        if (i_pyld_data_ready) begin
          rd_ptr_d = rd_ptr_q + 8'd1;
          if (rd_ptr_q == LAST_IDX) begin
            pyld_valid_d = 1'b0;
            pyld_last_d  = 1'b0;
            if (i_arq_en) begin
              state_d   = ACK;
              ack_d     = 1'b1;
              ack_cnt_d = '0;
            end else begin
              state_d = HUNT;
            end
          end else begin
            pyld_data_d = pyld_buf[rd_ptr_d[IDX_W-1:0]];
            pyld_last_d = (rd_ptr_d == LAST_IDX);
          end
        end
      end

      ACK: begin
        ack_cnt_d = ack_cnt_q + 1'b1;
        if (ack_cnt_q == ACK_LAST) begin
          ack_d   = 1'b0;
          state_d = HUNT;
          shreg_d = 16'hFFFF;
        end
      end

      default: state_d = HUNT;
    endcase

    sync_d = (state_d == RECV);
  end

  // State, counters and registered outputs; reset drops any partial frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= HUNT;
      shreg_q      <= 16'hFFFF;
      bit_cnt_q    <= 3'd0;
      byte_cnt_q   <= 8'd0;
      byte_sr_q    <= 8'd0;
      rx_crc_q     <= 8'd0;
      rd_ptr_q     <= 8'd0;
      ack_cnt_q    <= '0;
      pyld_data_q  <= 8'd0;
      pyld_valid_q <= 1'b0;
      pyld_last_q  <= 1'b0;
      ack_q        <= 1'b0;
      frame_ok_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      sync_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      byte_sr_q    <= byte_sr_d;
      rx_crc_q     <= rx_crc_d;
      rd_ptr_q     <= rd_ptr_d;
      ack_cnt_q    <= ack_cnt_d;
      pyld_data_q  <= pyld_data_d;
      pyld_valid_q <= pyld_valid_d;
      pyld_last_q  <= pyld_last_d;
      ack_q        <= ack_d;
      frame_ok_q   <= frame_ok_d;
      frame_err_q  <= frame_err_d;
      sync_q       <= sync_d;
    end
  end

  // Payload buffer write port.
  always_ff @(posedge i_clk) begin
    // NOTE: the buffer has no reset; every entry is rewritten before it can be drained.
    if (buf_we) pyld_buf[buf_waddr] <= byte_sr_d;
  end

  assign o_pyld_data       = pyld_data_q;
  assign o_pyld_data_valid = pyld_valid_q;
  assign o_pyld_last       = pyld_last_q;
  assign o_otn_tx_ack      = ack_q;
  assign o_frame_ok        = frame_ok_q;
  assign o_frame_err       = frame_err_q;
  assign o_sync            = sync_q;

endmodule

// File: doc/otn_frame_rx.md
Name: otn_frame_rx

Overview:
- Receive-side line terminator that consumes the serial OTN-style line driven by the sender's transmit path.
- Hunts for the frame alignment signal (FAS), assembles payload bytes into an internal frame buffer, checks the trailing CRC-8, and releases good payload bytes to a byte stream feeding the receive UART TX FIFO.
- Returns the ARQ acknowledge to the sender on the ack line.

Parameters:
- PYLD_LEN, 4, payload bytes per frame (range 1–255).
- ACK_LEN, 16, clocks that o_otn_tx_ack is held high per good frame.
- FAS_WORD, 16'hF628, frame alignment pattern, transmitted MSB first.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  synchronous, active-high reset
- i_otn_data  in  1  serial line bit, MSB first, idle level 1
- i_otn_data_en  in  1  bit strobe; i_otn_data is sampled only when this is 1
- i_arq_en  in  1  ARQ switch; 1 = CRC gating and ack enabled
- o_pyld_data  out  8  payload byte
- o_pyld_data_valid  out  1  payload byte valid
- i_pyld_data_ready  in  1  downstream ready
- o_pyld_last  out  1  marks the last payload byte of a frame
- o_otn_tx_ack  out  1  ack level to sender
- o_frame_ok  out  1  one-cycle pulse on CRC pass
- o_frame_err  out  1  one-cycle pulse on CRC fail
- o_sync  out  1  high while in RECV

Behaviour:
- Reset: every output is 0, the state is HUNT, the 16-bit shift register is loaded with 16'hFFFF, and all counters are cleared. Reset aborts any state; a partially buffered frame is dropped.
- HUNT:
  - On each strobe, shift i_otn_data into the LSB of the 16-bit shift register.
  - The compare uses the post-shift value. When it equals FAS_WORD, go to RECV on the next clock.
  - Bit and byte counters clear, and the CRC is set to 8'h00.
- RECV:
  - Strobed bits are assembled MSB first.
  - Every 8th bit writes the byte to buf[byte_cnt] and increments byte_cnt.
  - Bytes 0..PYLD_LEN-1 are payload. They feed a serial CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR), one bit per strobe.
  - Byte PYLD_LEN is the received CRC. It is not written to the buffer; it is latched to rx_crc, then go to CHECK.
- CHECK (1 cycle):
  - pass = (crc == rx_crc).
  - If pass: pulse o_frame_ok.
  - Otherwise: pulse o_frame_err.
  - If pass or i_arq_en=0, go to DRAIN with rd_ptr=0. Otherwise go to HUNT; the frame is discarded and no ack is sent, so the sender times out and retransmits.
- DRAIN:
  - o_pyld_data = buf[rd_ptr] and o_pyld_data_valid=1.
  - o_pyld_last = (rd_ptr == PYLD_LEN-1).
  - Once asserted, valid and data hold until i_pyld_data_ready is sampled high.
  - On a transfer, rd_ptr increments; the last transfer exits DRAIN.
  - Exit goes to ACK if i_arq_en=1, otherwise to HUNT.
- ACK:
  - o_otn_tx_ack=1 for exactly ACK_LEN clocks, then go to HUNT with the shift register reset to 16'hFFFF.
- Line bits during CHECK, DRAIN and ACK are ignored. The sender transmits nothing between a frame and its ack.
- i_arq_en is sampled in CHECK and at DRAIN exit only.
- Latencies:
  - Last CRC bit strobe → CHECK: 1 clock.
  - CHECK → first o_pyld_data_valid: 1 clock.
  - Last drained byte accepted → o_otn_tx_ack high: 1 clock.
- Counter widths: byte_cnt and rd_ptr are 8 bits; bit_cnt is 3 bits and wraps at 7→0; the ACK counter is $clog2(ACK_LEN+1) bits.
- A FAS pattern appearing inside the payload has no effect outside HUNT.

Decomposition:
- Package otn_frame_pkg holds:
  - FAS default 16'hF628
  - CRC8_POLY 8'h07
  - CRC8_INIT 8'h00
  - State encoding: HUNT=0, RECV=1, CHECK=2, DRAIN=3, ACK=4
- One sub-module, crc8_serial. Ports: clk, rst, clr, bit_en, bit_in, crc[7:0]. The sender's mapper CRC generator reuses it.

Test Plan:
- Good frame, ARQ on (PYLD_LEN=4): line bits 1111, F6 28, 01 02 03 04, E3.
  - Expect o_frame_ok pulse.
  - Expect bytes 01,02,03,04 with o_pyld_last on 04.
  - Expect o_otn_tx_ack high for 16 clocks, then o_sync=0 (back to HUNT).
- Corrupt CRC (E2 instead of E3), ARQ on:
  - Expect o_frame_err pulse.
  - No o_pyld_data_valid and no ack; the block returns to HUNT.
  - An immediate resend of the good frame is then delivered and acked.
- Same corrupt frame with i_arq_en=0:
  - Expect o_frame_err pulse.
  - Bytes 01..04 are still delivered; o_otn_tx_ack stays 0.
- Backpressure:
  - Hold i_pyld_data_ready=0 for 10 clocks after valid rises.
  - Data stays 01 and valid stays 1 throughout.
  - Toggling ready 1/0 still yields exactly 01,02,03,04 in order.
- False lock / noise:
  - Precede FAS with bits forming F6 27 plus random idle, and strobe i_otn_data_en every 3rd clock.
  - No lock on F627; lock only on F628; the frame is delivered correctly.
- Reset mid-RECV:
  - Assert i_rst after 2 payload bytes.
  - All outputs go to 0 and the state returns to HUNT.
  - A following good frame is delivered intact.
